// File: rtl/rr_gather32.sv
// rr_gather32: 32-to-1 round-robin gather stage.
//
// Collects words from up to N valid/ready source channels and forwards one per cycle to a single
// registered output. out_sel reports the source channel index using the same encoding as the
// matching 1:32 demux select. Arbitration is round-robin fair. force_en restricts eligibility to
// channel force_sel for directed routing.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    packed channel data, channel i = in_data[i*DW +: DW]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   force_en   1 = only channel force_sel is eligible
//   force_sel  forced channel index
//   out_data   registered output word
//   out_sel    registered source index of out_data
//   out_valid  output register holds a word
//   out_ready  downstream accepts
//   xfer_cnt   (GATHER_STATS_EN) input transfer count, wraps
//   stall_cnt  (GATHER_STATS_EN) cycles held FULL with out_ready low, saturates
//
// Build option: define GATHER_STATS_EN to add the xfer_cnt / stall_cnt counters and ports.

module rr_gather32 #(
   parameter int unsigned DW = 32,
   parameter int unsigned N  = 32,
   parameter int unsigned SW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*DW-1:0] in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   input  logic            force_en,
   input  logic [SW-1:0]   force_sel,
   output logic [DW-1:0]   out_data,
   output logic [SW-1:0]   out_sel,
   output logic            out_valid,
   input  logic            out_ready
`ifdef GATHER_STATS_EN
   ,
   output logic [31:0]     xfer_cnt,
   output logic [15:0]     stall_cnt
`endif
);

   typedef enum logic {StEmpty, StFull} state_e;

   localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

   state_e        state_q;
   logic [SW-1:0] rr_ptr_q;
   logic [N-1:0]  eligible;
   logic [N-1:0]  rotated;
   logic [2*N-1:0] doubled;
   logic [SW-1:0] offset;
   logic [SW-1:0] grant;
   logic          any_elig;
   logic          load;
   logic          in_xfer;

   // Rotate eligibility so rr_ptr sits at bit 0; the lowest set bit of the rotated vector is the
   // first eligible channel at or after rr_ptr. Adding rr_ptr back wraps naturally at SW bits.
   always_comb begin
      eligible = in_valid;
      if (force_en) begin
         eligible = in_valid & (One << force_sel);
      end
      doubled  = {eligible, eligible} >> rr_ptr_q;
      rotated  = doubled[N-1:0];
      any_elig = |eligible;
      offset   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            offset = SW'(i);
         end
      end
      grant = offset + rr_ptr_q;
   end

   assign load      = (state_q == StEmpty) | out_ready;
   assign in_xfer   = load & any_elig;
   assign out_valid = (state_q == StFull);

   // rst_n gates in_ready so it drops immediately on reset assertion, not at the next edge.
   assign in_ready  = (rst_n && in_xfer) ? (One << grant) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StEmpty;
         out_data <= '0;
         out_sel  <= '0;
         rr_ptr_q <= '0;
      end else if (load) begin
         if (any_elig) begin
            state_q  <= StFull;
            out_data <= in_data[grant*DW +: DW];
            out_sel  <= grant;
            // Forced grants must not disturb the fairness order.
            if (!force_en) begin
               rr_ptr_q <= grant + 1'b1;
            end
         end else begin
            // Drain: data/sel keep their last value.
            state_q <= StEmpty;
         end
      end
   end

`ifdef GATHER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (in_xfer) begin
            xfer_cnt <= xfer_cnt + 32'd1;
         end
         if ((state_q == StFull) && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rr_gather32.sv
// Self-checking bench for rr_gather32: directed scenarios plus a randomized run, all checked
// against a behavioural model that searches channels in round-robin order with plain integers.
module tb_rr_gather32;

   localparam int DW = 32;
   localparam int N  = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic            force_en;
   logic [4:0]      force_sel;
   logic [DW-1:0]   out_data;
   logic [4:0]      out_sel;
   logic            out_valid;
   logic            out_ready;
`ifdef GATHER_STATS_EN
   logic [31:0]     xfer_cnt;
   logic [15:0]     stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Model state
   int          m_ptr;
   bit          m_full;
   logic [31:0] m_data;
   logic [4:0]  m_sel;
   logic [31:0] m_xfer;
   int          m_stall;

   always #5 clk = ~clk;

   rr_gather32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .force_en  (force_en),
      .force_sel (force_sel),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef GATHER_STATS_EN
      ,
      .xfer_cnt  (xfer_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   // First eligible channel starting from ptr, or -1.
   function automatic int pick(input logic [31:0] v, input bit fen, input int fsel, input int ptr);
      for (int k = 0; k < N; k++) begin
         int ch;
         ch = (ptr + k) % N;
         if (v[ch] && (!fen || ch == fsel)) return ch;
      end
      return -1;
   endfunction

   function automatic logic [31:0] exp_ready();
      int g;
      g = pick(in_valid, force_en, int'(force_sel), m_ptr);
      if ((!m_full || out_ready) && g >= 0) return 32'd1 << g;
      return 32'd0;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_full = 0; m_data = '0; m_sel = '0; m_xfer = '0; m_stall = 0;
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = $urandom;
   endtask

   // One clock edge; the model advances with the inputs present at that edge.
   task automatic tick();
      int g;
      bit ld;
      g  = pick(in_valid, force_en, int'(force_sel), m_ptr);
      ld = !m_full || out_ready;
      @(posedge clk);
      if (m_full && !out_ready && m_stall < 65535) m_stall++;
      if (ld) begin
         if (g >= 0) begin
            m_full = 1;
            m_data = in_data[g*DW +: DW];
            m_sel  = 5'(g);
            m_xfer = m_xfer + 1;
            if (!force_en) m_ptr = (g + 1) % N;
         end else begin
            m_full = 0;
         end
      end
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = '1; out_ready = 1'b1; force_en = 1'b0; force_sel = '0;
      rand_data();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++;
      if (out_sel !== 5'd0) begin n_fail++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
      n_checks++;
      if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_checks++;
      if (in_ready !== 32'd0) begin n_fail++; $display("FAIL reset_in_ready: got %h want 0", in_ready); end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 32'h1) begin n_fail++; $display("FAIL release_in_ready: got %h want 00000001", in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 5'd0 || out_data !== m_data) begin
         n_fail++;
         $display("FAIL release_first: got v=%b sel=%0d data=%h want v=1 sel=0 data=%h",
                  out_valid, out_sel, out_data, m_data);
      end
   endtask

   task automatic test_single();
      in_valid = 32'h20;
      in_data[5*DW +: DW] = 32'hA5A5A5A5;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 32'h20) begin n_fail++; $display("FAIL single_in_ready: got %h want 00000020", in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5 || out_sel !== 5'd5) begin
         n_fail++;
         $display("FAIL single_out: got v=%b data=%h sel=%0d want v=1 data=a5a5a5a5 sel=5",
                  out_valid, out_data, out_sel);
      end
      in_valid = '0;
      #1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_sel !== 5'd5) begin
         n_fail++;
         $display("FAIL drain: got v=%b sel=%0d want v=0 sel=5", out_valid, out_sel);
      end
   endtask

   task automatic test_rr_wrap();
      pulse_reset();
      in_valid = '1; out_ready = 1'b1;
      for (int i = 0; i < 34; i++) begin
         rand_data();
         #1;
         n_checks++;
         if (in_ready !== exp_ready()) begin
            n_fail++; $display("FAIL wrap_in_ready[%0d]: got %h want %h", i, in_ready, exp_ready());
         end
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_sel !== 5'(i % N) || out_data !== m_data) begin
            n_fail++;
            $display("FAIL wrap_seq[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                     i, out_valid, out_sel, out_data, i % N, m_data);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] held_data;
      logic [4:0]  held_sel;
      held_data = out_data;
      held_sel  = out_sel;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_data();
         #1;
         n_checks++;
         if (in_ready !== 32'd0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %h want 0", i, in_ready); end
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== held_data || out_sel !== held_sel) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got v=%b data=%h sel=%0d want v=1 data=%h sel=%0d",
                     i, out_valid, out_data, out_sel, held_data, held_sel);
         end
      end
`ifdef GATHER_STATS_EN
      n_checks++;
      if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
`endif
      out_ready = 1'b1;
   endtask

   task automatic test_force();
      pulse_reset();
      in_valid = '1; out_ready = 1'b1; force_en = 1'b0;
      repeat (3) begin rand_data(); #1; tick(); end
      force_en = 1'b1; force_sel = 5'd17;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         #1;
         n_checks++;
         if (in_ready !== 32'h0002_0000) begin
            n_fail++; $display("FAIL force_in_ready[%0d]: got %h want 00020000", i, in_ready);
         end
         tick();
         n_checks++;
         if (out_sel !== 5'd17 || out_data !== m_data) begin
            n_fail++; $display("FAIL force_sel[%0d]: got sel=%0d data=%h want sel=17 data=%h",
                               i, out_sel, out_data, m_data);
         end
      end
      force_en = 1'b0;
      #1;
      tick();
      n_checks++;
      if (out_sel !== 5'd3) begin n_fail++; $display("FAIL force_release: got sel=%0d want 3", out_sel); end
      // Forced channel absent: nothing is granted even though others are valid.
      force_en = 1'b1; force_sel = 5'd9; in_valid = ~(32'd1 << 9);
      #1;
      n_checks++;
      if (in_ready !== 32'd0) begin n_fail++; $display("FAIL force_absent_ready: got %h want 0", in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL force_absent_drain: got v=%b want 0", out_valid); end
      force_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      in_valid = '1; out_ready = 1'b1;
      repeat (4) begin rand_data(); #1; tick(); end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 32'd0) begin
         n_fail++; $display("FAIL reset_mid_async: got v=%b ready=%h want v=0 ready=0", out_valid, in_ready);
      end
`ifdef GATHER_STATS_EN
      n_checks++;
      if (xfer_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_mid_xfer_cnt: got %0d want 0", xfer_cnt); end
`endif
      rst_n = 1'b1;
      model_reset();
      #1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 5'd0) begin
         n_fail++; $display("FAIL reset_mid_resume: got v=%b sel=%0d want v=1 sel=0", out_valid, out_sel);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 5) == 0) ? '0 : ($urandom & $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         force_en  = ($urandom_range(0, 7) == 0);
         force_sel = 5'($urandom);
         rand_data();
         #1;
         n_checks++;
         if (in_ready !== exp_ready()) begin
            n_fail++; $display("FAIL rand_in_ready[%0d]: got %h want %h", i, in_ready, exp_ready());
         end
         tick();
         n_checks++;
         if (out_valid !== m_full || (m_full && (out_data !== m_data || out_sel !== m_sel))) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: got v=%b data=%h sel=%0d want v=%b data=%h sel=%0d",
                     i, out_valid, out_data, out_sel, m_full, m_data, m_sel);
         end
      end
`ifdef GATHER_STATS_EN
      n_checks++;
      if (xfer_cnt !== m_xfer) begin n_fail++; $display("FAIL rand_xfer_cnt: got %0d want %0d", xfer_cnt, m_xfer); end
      n_checks++;
      if (stall_cnt !== 16'(m_stall)) begin
         n_fail++; $display("FAIL rand_stall_cnt: got %0d want %0d", stall_cnt, m_stall);
      end
`endif
      force_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_data = '0; in_valid = '0; force_en = 1'b0; force_sel = '0; out_ready = 1'b0;
      test_reset();
      test_single();
      test_rr_wrap();
      test_stall();
      test_force();
      test_reset_mid();
      pulse_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
